// File: rtl/exec_sequencer.sv
// Single-issue instruction sequencer driving an 8x8 register file with 1-cycle reads.
// Walks each instruction through READ -> EXEC -> WB and runs an 8-bit ALU on the operands.
module exec_sequencer #(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_instr,
  output logic [RADDR_W-1:0] rd0_addr,
  output logic [RADDR_W-1:0] rd1_addr,
  input  logic [DATA_W-1:0]  rf_out0,
  input  logic [DATA_W-1:0]  rf_out1,
  output logic [RADDR_W-1:0] wr_addr,
  output logic               wr_en,
  output logic [DATA_W-1:0]  wr_data,
  output logic               flag_z,
  output logic               flag_c,
  output logic               done,
  output logic               illegal
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              c;
    logic              flag_upd;
    logic              wr;
    logic              ill;
  } alu_t;

  state_t             state, state_nxt;
  logic               accept;
  logic [3:0]         op_p0;
  logic [RADDR_W-1:0] rd_p0;
  logic [7:0]         imm_p0;
  alu_t               alu_p1;

  function automatic alu_t alu(input logic [3:0] op, input logic [DATA_W-1:0] a,
                               input logic [DATA_W-1:0] b, input logic [7:0] imm);
    alu_t          r;
    logic [DATA_W:0] ext;
    r   = '0;
    ext = '0;
    case (op)
      4'h0: ;
      4'h1: begin
        ext = {1'b0, a} + {1'b0, b};
        r.res = ext[DATA_W-1:0]; r.c = ext[DATA_W]; r.flag_upd = 1'b1; r.wr = 1'b1;
      end
      4'h2: begin
        // Borrow lands in the extension bit when A < B
        ext = {1'b0, a} - {1'b0, b};
        r.res = ext[DATA_W-1:0]; r.c = ext[DATA_W]; r.flag_upd = 1'b1; r.wr = 1'b1;
      end
      4'h3: begin r.res = a & b; r.flag_upd = 1'b1; r.wr = 1'b1; end
      4'h4: begin r.res = a | b; r.flag_upd = 1'b1; r.wr = 1'b1; end
      4'h5: begin r.res = a ^ b; r.flag_upd = 1'b1; r.wr = 1'b1; end
      4'h6: begin r.res = DATA_W'(imm); r.wr = 1'b1; end
      4'h7: begin r.res = a; r.wr = 1'b1; end
      4'h8: begin
        r.res = {a[DATA_W-2:0], 1'b0}; r.c = a[DATA_W-1]; r.flag_upd = 1'b1; r.wr = 1'b1;
      end
      4'h9: begin
        r.res = {1'b0, a[DATA_W-1:1]}; r.c = a[0]; r.flag_upd = 1'b1; r.wr = 1'b1;
      end
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = READ;
      end
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      WB: begin
        in_ready  = 1'b1;
        state_nxt = in_valid ? READ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // Stage p0: latch instruction fields on accept; read addresses hold through EXEC
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0  <= in_instr[15:12];
      rd_p0  <= in_instr[11:9];
      imm_p0 <= in_instr[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_addr <= '0;
      rd1_addr <= '0;
    end else if (accept) begin
      rd0_addr <= in_instr[8:6];
      rd1_addr <= in_instr[5:3];
    end
  end

  // Stage p1: operands arrive in EXEC; result and flags registered into WB
  assign alu_p1 = alu(op_p0, rf_out0, rf_out1, imm_p0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      if (state == EXEC) begin
        wr_en   <= alu_p1.wr;
        done    <= 1'b1;
        illegal <= alu_p1.ill;
        wr_addr <= rd_p0;
        wr_data <= alu_p1.res;
        if (alu_p1.flag_upd) begin
          flag_z <= (alu_p1.res == '0);
          flag_c <= alu_p1.c;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer with a behavioural 8x8 register file (1-cycle reads).
// The driver pushes hand-computed expectations on accept; a monitor pops them on done.
module tb_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [15:0] in_instr;
  logic [2:0] rd0_addr, rd1_addr, wr_addr;
  logic [7:0] rf_out0, rf_out1, wr_data;
  logic       wr_en, flag_z, flag_c, done, illegal;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic       z;
    logic       c;
    logic       ill;
    int         acc_cyc;
    int         id;
  } exp_t;

  exp_t sb[$];
  logic [7:0] rf [8];

  exec_sequencer #(.DATA_W(8), .RADDR_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .rf_out0(rf_out0), .rf_out1(rf_out1),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .flag_z(flag_z), .flag_c(flag_c),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: registered reads see the old value if written on the same edge
  initial for (int i = 0; i < 8; i++) rf[i] = 8'h00;
  always @(posedge clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
    rf_out0 <= rf[rd0_addr];
    rf_out1 <= rf[rd1_addr];
  end

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (instr %0d): got 0x%0h expected 0x%0h", name, id, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {4'h6, rd, 1'b0, imm};
  endfunction

  int next_id = 0;

  task automatic send(input logic [15:0] instr, input logic wr, input logic [2:0] addr,
                      input logic [7:0] data, input logic z, input logic c, input logic ill);
    exp_t e;
    int t;
    t = 0;
    in_valid = 1'b1;
    in_instr = instr;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        $display("FAIL accept_timeout (instr %0d): in_ready never rose", next_id);
        $fatal(1);
      end
    end
    e.wr = wr; e.addr = addr; e.data = data; e.z = z; e.c = c; e.ill = ill;
    e.acc_cyc = cyc; e.id = next_id;
    next_id++;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = 16'hFFFF;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    chk("drain_empty", -1, sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", -1, 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", e.id, cyc - e.acc_cyc, 3);
          chk("wr_en", e.id, wr_en, e.wr);
          chk("illegal", e.id, illegal, e.ill);
          chk("flag_z", e.id, flag_z, e.z);
          chk("flag_c", e.id, flag_c, e.c);
          if (e.wr) begin
            chk("wr_addr", e.id, wr_addr, e.addr);
            chk("wr_data", e.id, wr_data, e.data);
          end
        end
      end else if (wr_en || illegal) begin
        chk("strobe_without_done", -1, {wr_en, illegal}, 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", -1, in_ready, 1);
    chk("rst_wr_en", -1, wr_en, 0);
    chk("rst_done", -1, done, 0);
    chk("rst_flags", -1, {flag_z, flag_c}, 0);
    chk("rst_wr_data", -1, wr_data, 0);
    chk("rst_rd0_addr", -1, rd0_addr, 0);
    @(posedge clk);
    #1;

    // LDI, then arithmetic with carry and borrow
    send(ldi(3'd1, 8'h5A), 1, 3'd1, 8'h5A, 0, 0, 0);
    drain();
    send(ldi(3'd1, 8'hF0), 1, 3'd1, 8'hF0, 0, 0, 0);
    send(ldi(3'd2, 8'h20), 1, 3'd2, 8'h20, 0, 0, 0);
    send(alu_i(4'h1, 3'd3, 3'd1, 3'd2), 1, 3'd3, 8'h10, 0, 1, 0);
    send(alu_i(4'h2, 3'd4, 3'd2, 3'd1), 1, 3'd4, 8'h30, 0, 1, 0);
    // XOR to zero, then MOV keeps flags
    send(alu_i(4'h5, 3'd5, 3'd1, 3'd1), 1, 3'd5, 8'h00, 1, 0, 0);
    send(alu_i(4'h7, 3'd6, 3'd1, 3'd0), 1, 3'd6, 8'hF0, 1, 0, 0);
    // Back-to-back: ADD reads r2 written by the LDI one cycle earlier
    send(ldi(3'd2, 8'h07), 1, 3'd2, 8'h07, 1, 0, 0);
    send(alu_i(4'h1, 3'd3, 3'd2, 3'd2), 1, 3'd3, 8'h0E, 0, 0, 0);
    send(alu_i(4'h3, 3'd3, 3'd1, 3'd2), 1, 3'd3, 8'h00, 1, 0, 0);
    send(alu_i(4'h4, 3'd4, 3'd1, 3'd2), 1, 3'd4, 8'hF7, 0, 0, 0);
    send(alu_i(4'h8, 3'd7, 3'd1, 3'd0), 1, 3'd7, 8'hE0, 0, 1, 0);
    send(alu_i(4'h9, 3'd7, 3'd1, 3'd0), 1, 3'd7, 8'h78, 0, 0, 0);
    send(alu_i(4'h2, 3'd4, 3'd1, 3'd2), 1, 3'd4, 8'hE9, 0, 0, 0);
    send(alu_i(4'h9, 3'd6, 3'd2, 3'd0), 1, 3'd6, 8'h03, 0, 1, 0);
    send(alu_i(4'h1, 3'd4, 3'd5, 3'd5), 1, 3'd4, 8'h00, 1, 0, 0);
    // Illegal opcode and NOP: no write, flags held
    send(alu_i(4'hC, 3'd1, 3'd1, 3'd1), 0, 3'd0, 8'h00, 1, 0, 1);
    send(alu_i(4'h0, 3'd1, 3'd1, 3'd1), 0, 3'd0, 8'h00, 1, 0, 0);
    send(alu_i(4'h7, 3'd0, 3'd4, 3'd0), 1, 3'd0, 8'h00, 1, 0, 0);
    drain();

    // Reset during EXEC abandons the ADD
    in_valid = 1'b1;
    in_instr = alu_i(4'h1, 3'd5, 3'd1, 3'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", -1, in_ready, 1);
    chk("abort_wr_en", -1, wr_en, 0);
    chk("abort_done", -1, done, 0);
    chk("abort_flags", -1, {flag_z, flag_c}, 0);
    repeat (4) @(negedge clk);
    chk("abort_rf_r5_untouched", -1, rf[5], 8'h00);
    @(posedge clk);
    #1;

    send(ldi(3'd0, 8'h33), 1, 3'd0, 8'h33, 0, 0, 0);
    send(alu_i(4'h1, 3'd5, 3'd0, 3'd0), 1, 3'd5, 8'h66, 0, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
